// File: rtl/temperature_to_adc_encoder_pkg.sv
// temperature_to_adc_encoder_pkg: shared widths, FSM states and adc code field helpers
package temperature_to_adc_encoder_pkg;
  localparam int BASE_W = 32;
  localparam int REF_W = 8;
  localparam int ADC_W = 16;
  localparam int SHIFT = 6;
  localparam int NW = BASE_W + 1 + SHIFT;
  localparam int DEN_W = 2 * REF_W;
  localparam int CNT_W = $clog2(NW);
  localparam logic [ADC_W-2:0] MAG_MAX = '1;
  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
  function automatic logic [ADC_W-1:0] adc_pack(input logic s, input logic [ADC_W-2:0] m);
    return {s, m};
  endfunction
  function automatic logic adc_sign(input logic [ADC_W-1:0] c);
    return c[ADC_W-1];
  endfunction
  function automatic logic [ADC_W-2:0] adc_mag(input logic [ADC_W-1:0] c);
    return c[ADC_W-2:0];
  endfunction
endpackage

// File: rtl/temperature_to_adc_encoder_udiv_restoring.sv
// temperature_to_adc_encoder_udiv_restoring: sequential restoring divider, one quotient bit per cycle
module temperature_to_adc_encoder_udiv_restoring
  import temperature_to_adc_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW-1:0]    num,
  input  logic [DEN_W-1:0] den,
  output logic [NW-1:0]    q_nxt,
  output logic             last
);
  logic [NW-1:0] n_q, n_d, q_q, q_d;
  logic [DEN_W-1:0] d_q, d_d, r_q, r_d, sub;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, ge;
  logic [DEN_W:0] r_t;
  // dividend shifts out MSB first; remainder fits DEN_W bits since it stays below den
  always_comb begin
    r_t = {r_q, n_q[NW-1]};
    ge = r_t >= {1'b0, d_q};
    sub = r_t[DEN_W-1:0] - d_q;
    q_nxt = {q_q[NW-2:0], ge};
    last = busy_q && cnt_q == '0;
    n_d = start ? num : busy_q ? n_q << 1 : n_q;
    d_d = start ? den : d_q;
    r_d = start ? '0 : busy_q ? (ge ? sub : r_t[DEN_W-1:0]) : r_q;
    q_d = start ? '0 : busy_q ? q_nxt : q_q;
    cnt_d = start ? CNT_W'(NW - 1) : busy_q ? cnt_q - 1'b1 : cnt_q;
    busy_d = start || (busy_q && !last);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      d_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      n_q <= n_d;
      d_q <= d_d;
      r_q <= r_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/temperature_to_adc_encoder.sv
// temperature_to_adc_encoder: inverse temperature path, sensor code = (|tempc - tc_base| << SHIFT) / tc_ref^2
module temperature_to_adc_encoder
  import temperature_to_adc_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BASE_W-1:0] tc_base,
  input  logic [REF_W-1:0]  tc_ref,
  input  logic [BASE_W-1:0] tempc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADC_W-1:0]  adc_data,
  output logic              sat,
  output logic              div_zero
);
  state_t state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d, temp_q, temp_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [ADC_W-1:0] adc_q, adc_d;
  logic sat_q, sat_d, dz_q, dz_d, div_last, fin, clip, dz;
  logic [BASE_W:0] diff, mag;
  logic [NW-1:0] num, q_nxt;
  logic [DEN_W-1:0] den;
  temperature_to_adc_encoder_udiv_restoring u_div (
    .clk(clk), .rst_n(rst_n), .start(state_q == PREP), .num(num), .den(den),
    .q_nxt(q_nxt), .last(div_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? PREP : IDLE) :
              state_q == PREP ? DIV :
              state_q == DIV ? (div_last ? DONE : DIV) :
              (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  // captured operands stay put through the divide, so sign and div-zero are taken from them at the finish
  always_comb begin
    diff = {temp_q[BASE_W-1], temp_q} - {base_q[BASE_W-1], base_q};
    mag = diff[BASE_W] ? -diff : diff;
    num = {mag, SHIFT'(0)};
    den = ref_q * ref_q;
    fin = state_q == DIV && div_last;
    clip = |q_nxt[NW-1:ADC_W-1];
    dz = ref_q == '0;
    base_d = in_ready && in_valid ? tc_base : base_q;
    temp_d = in_ready && in_valid ? tempc : temp_q;
    ref_d = in_ready && in_valid ? tc_ref : ref_q;
    adc_d = fin ? adc_pack(diff[BASE_W], (dz || clip) ? MAG_MAX : q_nxt[ADC_W-2:0]) : adc_q;
    sat_d = fin ? dz || clip : sat_q;
    dz_d = fin ? dz : dz_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      temp_q <= '0;
      ref_q <= '0;
      adc_q <= '0;
      sat_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      base_q <= base_d;
      temp_q <= temp_d;
      ref_q <= ref_d;
      adc_q <= adc_d;
      sat_q <= sat_d;
      dz_q <= dz_d;
    end
  end
  assign adc_data = adc_q;
  assign sat = sat_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_temperature_to_adc_encoder.sv
// tb_temperature_to_adc_encoder: directed vector table plus stall and mid-divide reset sequences
module tb_temperature_to_adc_encoder;
  import temperature_to_adc_encoder_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, sat, div_zero;
  logic [BASE_W-1:0] tc_base = '0, tempc = '0;
  logic [REF_W-1:0] tc_ref = '0;
  logic [ADC_W-1:0] adc_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] base;
    logic [7:0]  rf;
    logic [31:0] temp;
    logic [15:0] adc;
    logic        sat;
    logic        dz;
  } vec_t;
  vec_t vt[15];
  temperature_to_adc_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .tc_base(tc_base), .tc_ref(tc_ref), .tempc(tempc), .out_valid(out_valid),
    .out_ready(out_ready), .adc_data(adc_data), .sat(sat), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input string nm, input bit hold);
    int lat;
    @(negedge clk);
    tc_base = t.base;
    tc_ref = t.rf;
    tempc = t.temp;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk({nm, " in_ready busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 40);
    chk({nm, " adc"}, adc_data, t.adc);
    chk({nm, " sat"}, sat, t.sat);
    chk({nm, " div_zero"}, div_zero, t.dz);
    if (!hold) begin
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      chk({nm, " out_valid drop"}, out_valid, 0);
      chk({nm, " in_ready back"}, in_ready, 1);
    end
  endtask
  initial begin
    bit seen;
    vt[0]  = '{32'd25, 8'd4, 32'd25, 16'h0000, 0, 0};
    vt[1]  = '{32'd20, 8'd4, 32'd30, 16'h0028, 0, 0};
    vt[2]  = '{32'd0, 8'd3, 32'd1, 16'h0007, 0, 0};
    vt[3]  = '{32'd100, 8'd2, 32'd90, 16'h80A0, 0, 0};
    vt[4]  = '{32'd0, 8'd1, 32'd100000, 16'h7FFF, 1, 0};
    vt[5]  = '{32'd0, 8'd0, -32'sd5, 16'hFFFF, 1, 1};
    vt[6]  = '{32'd0, 8'd0, 32'd5, 16'h7FFF, 1, 1};
    vt[7]  = '{32'd1, 8'd3, 32'd0, 16'h8007, 0, 0};
    vt[8]  = '{32'd0, 8'd8, 32'd32767, 16'h7FFF, 0, 0};
    vt[9]  = '{32'd0, 8'd8, 32'd32768, 16'h7FFF, 1, 0};
    vt[10] = '{32'd0, 8'd255, 32'd1000, 16'h0000, 0, 0};
    vt[11] = '{32'h80000000, 8'd255, 32'h7FFFFFFF, 16'h7FFF, 1, 0};
    vt[12] = '{32'h7FFFFFFF, 8'd255, 32'h80000000, 16'hFFFF, 1, 0};
    vt[13] = '{32'd0, 8'd0, 32'd0, 16'h7FFF, 1, 1};
    vt[14] = '{32'd0, 8'd1, 32'd511, 16'h7FC0, 0, 0};
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset adc", adc_data, 0);
    chk("reset sat", sat, 0);
    chk("reset div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 15; i++) run(vt[i], $sformatf("vec%0d", i), 0);
    run(vt[1], "stall", 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tc_base = vt[3].base;
      tc_ref = vt[3].rf;
      tempc = vt[3].temp;
      in_valid = 1;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d adc", c), adc_data, 16'h0028);
      chk($sformatf("stall%0d out_valid", c), out_valid, 1);
      chk($sformatf("stall%0d in_ready", c), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("release out_valid", out_valid, 0);
    chk("release no bypass", in_ready, 1);
    run(vt[3], "after stall", 0);
    @(negedge clk);
    tc_base = vt[4].base;
    tc_ref = vt[4].rf;
    tempc = vt[4].temp;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset adc", adc_data, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("midreset in_ready", in_ready, 1);
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("midreset no stale result", seen, 0);
    run(vt[2], "post reset", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
